// File: rtl/pipeline_hazard_controller_if.sv
// rtl/pipeline_hazard_controller_if.sv - data memory req/ack handshake bundle
//
// Purpose: carries the data-memory access handshake between the hazard
// controller (master, raises dmem_req) and the data memory (slave, answers
// with dmem_ack).
// Signals:
//   dmem_req  master->slave  access request, held until ack is sampled
//   dmem_ack  slave->master  access complete this cycle
interface pipeline_hazard_controller_if;
   logic dmem_req;
   logic dmem_ack;

   modport master (output dmem_req, input dmem_ack);
   modport slave  (input dmem_req, output dmem_ack);
endinterface

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - 5-stage pipeline stall/flush sequencer
//
// Purpose: drives enables and bubble-insert (flush) controls for the PC and
// the IF/ID, ID/EX, EX/MEM, MEM/WB registers. Handles data-memory waits,
// taken branches resolved in MEM, load-use hazards and fetch bubbles, in
// that priority order.
// Optional feature macro: PIPE_CTRL_PERF_EN adds the CNT_WIDTH parameter and
// saturating stall_cycles / flush_events counters.
// Ports:
//   clk, reset_n                clock, asynchronous active-low reset
//   rs1_addr_id, rs2_addr_id    ID source registers
//   uses_rs1_id, uses_rs2_id    ID instruction reads rs1/rs2
//   rd_ex, MemRead_ex           EX destination / EX is a load
//   MemRead_mem, MemWrite_mem   MEM accesses data memory
//   branch_taken_mem            branch resolved taken in MEM
//   imem_valid                  fetched instruction valid
//   dmem                        data-memory req/ack (master modport)
//   pc_select_branch            PC mux selects branch target
//   *_enable, *_flush           register enables / bubble inserts
//   stall_cycles, flush_events  perf counters (PIPE_CTRL_PERF_EN only)
module pipeline_hazard_controller
`ifdef PIPE_CTRL_PERF_EN
   #(parameter int CNT_WIDTH = 32)
`endif
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  rs1_addr_id,
   input  logic [4:0]  rs2_addr_id,
   input  logic        uses_rs1_id,
   input  logic        uses_rs2_id,
   input  logic [4:0]  rd_ex,
   input  logic        MemRead_ex,
   input  logic        MemRead_mem,
   input  logic        MemWrite_mem,
   input  logic        branch_taken_mem,
   input  logic        imem_valid,
   pipeline_hazard_controller_if.master dmem,
   output logic        pc_select_branch,
   output logic        pc_enable,
   output logic        if_id_enable,
   output logic        id_ex_enable,
   output logic        ex_mem_enable,
   output logic        mem_wb_enable,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        ex_mem_flush,
   output logic        mem_wb_flush
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] flush_events
`endif
);

   typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

   state_t state;
   state_t next_state;

   logic mem_op;
   logic load_use;
   logic mem_waiting;

   assign mem_op = MemRead_mem | MemWrite_mem;

   // x0 is hardwired zero, so a load targeting it never creates a hazard.
   assign load_use = MemRead_ex && (rd_ex != 5'd0) &&
                     ((uses_rs1_id && (rs1_addr_id == rd_ex)) ||
                      (uses_rs2_id && (rs2_addr_id == rd_ex)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state       = state;
      mem_waiting      = 1'b0;
      dmem.dmem_req    = 1'b0;
      pc_select_branch = 1'b0;
      pc_enable        = 1'b0;
      if_id_enable     = 1'b0;
      id_ex_enable     = 1'b0;
      ex_mem_enable    = 1'b0;
      mem_wb_enable    = 1'b0;
      if_id_flush      = 1'b0;
      id_ex_flush      = 1'b0;
      ex_mem_flush     = 1'b0;
      mem_wb_flush     = 1'b0;

      // Outputs are forced low while reset is held so an abandoned access
      // drops dmem_req in the same cycle, without waiting for a clock.
      if (reset_n) begin
         case (state)
            RUN: begin
               dmem.dmem_req = mem_op;
               if (mem_op && !dmem.dmem_ack) begin
                  mem_waiting = 1'b1;
                  next_state  = MEM_WAIT;
               end
            end
            MEM_WAIT: begin
               // Request stays up through the ack cycle; on that cycle the
               // pipeline is released and mem_op no longer matters.
               dmem.dmem_req = 1'b1;
               if (dmem.dmem_ack) begin
                  next_state = RUN;
               end else begin
                  mem_waiting = 1'b1;
               end
            end
            default: begin
               next_state = RUN;
            end
         endcase

         if (mem_waiting) begin
            // Freeze everything upstream of MEM; let WB drain with a bubble
            // so the access result is not written back twice.
            mem_wb_enable = 1'b1;
            mem_wb_flush  = 1'b1;
         end else if (branch_taken_mem) begin
            pc_select_branch = 1'b1;
            pc_enable        = 1'b1;
            if_id_enable     = 1'b1;
            id_ex_enable     = 1'b1;
            ex_mem_enable    = 1'b1;
            mem_wb_enable    = 1'b1;
            if_id_flush      = 1'b1;
            id_ex_flush      = 1'b1;
            ex_mem_flush     = 1'b1;
         end else if (load_use) begin
            id_ex_enable  = 1'b1;
            ex_mem_enable = 1'b1;
            mem_wb_enable = 1'b1;
            id_ex_flush   = 1'b1;
         end else if (!imem_valid) begin
            if_id_enable  = 1'b1;
            id_ex_enable  = 1'b1;
            ex_mem_enable = 1'b1;
            mem_wb_enable = 1'b1;
            if_id_flush   = 1'b1;
         end else begin
            pc_enable     = 1'b1;
            if_id_enable  = 1'b1;
            id_ex_enable  = 1'b1;
            ex_mem_enable = 1'b1;
            mem_wb_enable = 1'b1;
         end
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   // pc_select_branch is only high on the cycle a taken branch is applied,
   // so each branch is counted once even if it sat behind a memory wait.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (!pc_enable && (stall_cycles != {CNT_WIDTH{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
         end
         if (pc_select_branch && (flush_events != {CNT_WIDTH{1'b1}})) begin
            flush_events <= flush_events + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed self-checking bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

    localparam int CNT_W = 4;

    localparam logic [10:0] C_RESET   = 11'b00_00000_0000;
    localparam logic [10:0] C_NORMAL  = 11'b00_11111_0000;
    localparam logic [10:0] C_LOADUSE = 11'b00_00111_0100;
    localparam logic [10:0] C_BRANCH  = 11'b01_11111_1110;
    localparam logic [10:0] C_MEMWAIT = 11'b10_00001_0001;
    localparam logic [10:0] C_BUBBLE  = 11'b00_01111_1000;
    localparam logic [10:0] C_REQRUN  = 11'b10_11111_0000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] rs1_addr_id, rs2_addr_id, rd_ex;
    logic       uses_rs1_id, uses_rs2_id, MemRead_ex;
    logic       MemRead_mem, MemWrite_mem, branch_taken_mem, imem_valid;
    logic       pc_select_branch, pc_enable, if_id_enable, id_ex_enable;
    logic       ex_mem_enable, mem_wb_enable;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles, flush_events;
`endif
    logic [10:0] ctl;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_controller_if dmem_bus();

    always #5 clk = ~clk;

`ifdef PIPE_CTRL_PERF_EN
    pipeline_hazard_controller #(.CNT_WIDTH(CNT_W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rs1_addr_id(rs1_addr_id),
        .rs2_addr_id(rs2_addr_id),
        .uses_rs1_id(uses_rs1_id),
        .uses_rs2_id(uses_rs2_id),
        .rd_ex(rd_ex),
        .MemRead_ex(MemRead_ex),
        .MemRead_mem(MemRead_mem),
        .MemWrite_mem(MemWrite_mem),
        .branch_taken_mem(branch_taken_mem),
        .imem_valid(imem_valid),
        .dmem(dmem_bus.master),
        .pc_select_branch(pc_select_branch),
        .pc_enable(pc_enable),
        .if_id_enable(if_id_enable),
        .id_ex_enable(id_ex_enable),
        .ex_mem_enable(ex_mem_enable),
        .mem_wb_enable(mem_wb_enable),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush),
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );
`else
    pipeline_hazard_controller dut (
        .clk(clk),
        .reset_n(reset_n),
        .rs1_addr_id(rs1_addr_id),
        .rs2_addr_id(rs2_addr_id),
        .uses_rs1_id(uses_rs1_id),
        .uses_rs2_id(uses_rs2_id),
        .rd_ex(rd_ex),
        .MemRead_ex(MemRead_ex),
        .MemRead_mem(MemRead_mem),
        .MemWrite_mem(MemWrite_mem),
        .branch_taken_mem(branch_taken_mem),
        .imem_valid(imem_valid),
        .dmem(dmem_bus.master),
        .pc_select_branch(pc_select_branch),
        .pc_enable(pc_enable),
        .if_id_enable(if_id_enable),
        .id_ex_enable(id_ex_enable),
        .ex_mem_enable(ex_mem_enable),
        .mem_wb_enable(mem_wb_enable),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush)
    );
`endif

    assign ctl = {dmem_bus.dmem_req, pc_select_branch, pc_enable, if_id_enable,
                  id_ex_enable, ex_mem_enable, mem_wb_enable, if_id_flush,
                  id_ex_flush, ex_mem_flush, mem_wb_flush};

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_addr_id = 5'd0; rs2_addr_id = 5'd0; rd_ex = 5'd0;
        uses_rs1_id = 1'b0; uses_rs2_id = 1'b0; MemRead_ex = 1'b0;
        MemRead_mem = 1'b0; MemWrite_mem = 1'b0; branch_taken_mem = 1'b0;
        imem_valid = 1'b1; dmem_bus.dmem_ack = 1'b0;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        MemRead_mem = 1'b1;
        #2 check("reset_outputs", {21'd0, ctl}, {21'd0, C_RESET});

        tick(); reset_n = 1'b1; idle();
        #1 check("normal_after_release", {21'd0, ctl}, {21'd0, C_NORMAL});

        tick(); MemRead_ex = 1'b1; rd_ex = 5'd5; uses_rs1_id = 1'b1; rs1_addr_id = 5'd5;
        #1 check("load_use_rs1", {21'd0, ctl}, {21'd0, C_LOADUSE});
        tick(); idle();
        #1 check("after_load_use", {21'd0, ctl}, {21'd0, C_NORMAL});

        tick(); MemRead_ex = 1'b1; rd_ex = 5'd9; uses_rs2_id = 1'b1; rs2_addr_id = 5'd9;
        #1 check("load_use_rs2", {21'd0, ctl}, {21'd0, C_LOADUSE});

        uses_rs2_id = 1'b0;
        #1 check("unused_rs2_no_stall", {21'd0, ctl}, {21'd0, C_NORMAL});

        tick(); idle(); MemRead_ex = 1'b1; rd_ex = 5'd0; uses_rs1_id = 1'b1; rs1_addr_id = 5'd0;
        #1 check("load_x0_no_stall", {21'd0, ctl}, {21'd0, C_NORMAL});

        tick(); idle(); MemRead_ex = 1'b1; rd_ex = 5'd5; uses_rs1_id = 1'b1; rs1_addr_id = 5'd5;
        branch_taken_mem = 1'b1;
        #1 check("branch_over_load_use", {21'd0, ctl}, {21'd0, C_BRANCH});

        tick(); branch_taken_mem = 1'b0; imem_valid = 1'b0;
        #1 check("load_use_over_bubble", {21'd0, ctl}, {21'd0, C_LOADUSE});

        tick(); idle(); MemWrite_mem = 1'b1;
        #1 check("store_req_cycle0", {21'd0, ctl}, {21'd0, C_MEMWAIT});
        tick(); branch_taken_mem = 1'b1;
        #1 check("store_wait1_branch_masked", {21'd0, ctl}, {21'd0, C_MEMWAIT});
        tick(); branch_taken_mem = 1'b0;
        #1 check("store_wait2", {21'd0, ctl}, {21'd0, C_MEMWAIT});
        tick(); dmem_bus.dmem_ack = 1'b1;
        #1 check("store_ack_release", {21'd0, ctl}, {21'd0, C_REQRUN});
        tick(); idle();
        #1 check("after_store_run", {21'd0, ctl}, {21'd0, C_NORMAL});

        tick(); MemRead_mem = 1'b1; dmem_bus.dmem_ack = 1'b1;
        #1 check("load_zero_wait", {21'd0, ctl}, {21'd0, C_REQRUN});
        tick(); idle();
        #1 check("after_zero_wait_run", {21'd0, ctl}, {21'd0, C_NORMAL});

        tick(); imem_valid = 1'b0;
        #1 check("bubble_cycle1", {21'd0, ctl}, {21'd0, C_BUBBLE});
        tick();
        #1 check("bubble_cycle2", {21'd0, ctl}, {21'd0, C_BUBBLE});

        tick(); idle(); dmem_bus.dmem_ack = 1'b1;
        #1 check("stray_ack", {21'd0, ctl}, {21'd0, C_NORMAL});
        tick(); dmem_bus.dmem_ack = 1'b0;
        #1 check("after_stray_ack", {21'd0, ctl}, {21'd0, C_NORMAL});

        tick(); MemRead_mem = 1'b1;
        #1 check("load_wait_req", {21'd0, ctl}, {21'd0, C_MEMWAIT});
        tick();
        #1 check("load_in_mem_wait", {21'd0, ctl}, {21'd0, C_MEMWAIT});
        reset_n = 1'b0;
        #1 check("reset_in_mem_wait", {21'd0, ctl}, {21'd0, C_RESET});
        tick(); reset_n = 1'b1; idle();
        #1 check("post_reset_run", {21'd0, ctl}, {21'd0, C_NORMAL});
        tick();
        #1 check("post_reset_run2", {21'd0, ctl}, {21'd0, C_NORMAL});

`ifdef PIPE_CTRL_PERF_EN
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        #1 check("stall_cnt_reset", {28'd0, stall_cycles}, 32'd0);
        check("flush_cnt_reset", {28'd0, flush_events}, 32'd0);
        tick(); branch_taken_mem = 1'b1;
        tick(); branch_taken_mem = 1'b0;
        #1 check("flush_cnt_one", {28'd0, flush_events}, 32'd1);
        check("stall_cnt_after_branch", {28'd0, stall_cycles}, 32'd0);
        imem_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("stall_cnt_saturates", {28'd0, stall_cycles}, 32'd15);
        idle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
